// File: rtl/uart_transmitter.sv
// UART transmit half: captures a byte over a four-phase REQ/ACK handshake and
// shifts it out as start bit, 8 data bits LSB first, then STOP_BITS stop bits.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       XMIT_REQ,
    input  logic [7:0] XMIT_DATA,
    output logic       XMIT_ACK,
    output logic       XMIT_BUSY,
    output logic       TX
);

    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_tx, w_tx_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_bit_end;

    assign w_bit_end = (r_tmr == TMR_LAST);

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + TMR_W'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        // ACK release tracks REQ only, so it may drop while a frame is still going out
        w_ack_nxt   = r_ack;
        if (r_ack && !XMIT_REQ) begin
            w_ack_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                w_tmr_nxt = '0;
                w_idx_nxt = '0;
                if (XMIT_REQ && !r_ack) begin
                    w_shift_nxt = XMIT_DATA;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_tmr_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_tmr_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_idx_nxt   = '0;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // TX takes the bit that becomes shift[0] after this shift
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_idx_nxt   = r_idx + 3'd1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_tmr_nxt = '0;
                    if (r_idx == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
                w_idx_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign XMIT_ACK  = r_ack;
    assign XMIT_BUSY = r_busy;
    assign TX        = r_tx;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: default instance (8 clk/bit, 1 stop)
// and a fast instance (3 clk/bit, 2 stop); monitors decode every BUSY window.
module tb_uart_transmitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_a, req_a, ack_a, busy_a, tx_a;
    logic [7:0] data_a;
    logic       clr_b, req_b, ack_b, busy_b, tx_b;
    logic [7:0] data_b;

    uart_transmitter #(.CLKS_PER_BIT(8), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .clr(clr_a), .XMIT_REQ(req_a), .XMIT_DATA(data_a),
        .XMIT_ACK(ack_a), .XMIT_BUSY(busy_a), .TX(tx_a)
    );

    uart_transmitter #(.CLKS_PER_BIT(3), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .clr(clr_b), .XMIT_REQ(req_b), .XMIT_DATA(data_b),
        .XMIT_ACK(ack_b), .XMIT_BUSY(busy_b), .TX(tx_b)
    );

    typedef struct {
        logic [7:0] data;
        bit         abort;
        int         gap;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected line level for cycle i of a frame: start 0, data LSB first, then stop 1
    task automatic eval_frame(input string tag, input logic [127:0] wave, input int n,
                              input int cpb, input int stops, input exp_t e, input int gap);
        int         full;
        int         b;
        int         shape_ok;
        logic       lv;
        logic [7:0] dec;
        full     = (9 + stops) * cpb;
        shape_ok = 1;
        for (int i = 0; i < n && i < 128; i++) begin
            b = i / cpb;
            if (b == 0)      lv = 1'b0;
            else if (b <= 8) lv = e.data[b-1];
            else             lv = 1'b1;
            if (wave[i] !== lv) shape_ok = 0;
        end
        if (e.abort) begin
            check({tag, " abort_short"}, int'(n < full), 1);
        end else begin
            check({tag, " frame_len"}, n, full);
            for (int k = 0; k < 8; k++) dec[k] = wave[(k + 1) * cpb + cpb / 2];
            check({tag, " frame_data"}, int'(dec), int'(e.data));
        end
        check({tag, " frame_shape"}, shape_ok, 1);
        if (e.gap >= 0) check({tag, " busy_gap"}, gap, e.gap);
    endtask

    logic [127:0] wave_a;
    int           n_a    = 0;
    bit           inf_a  = 0;
    int           gapc_a = 0;
    always @(negedge clk) begin
        if (inf_a) begin
            if (busy_a === 1'b1) begin
                if (n_a < 128) wave_a[n_a] = tx_a;
                n_a++;
            end else begin
                inf_a = 0;
                if (q_a.size() == 0) check("A unexpected_frame", 1, 0);
                else eval_frame("A", wave_a, n_a, 8, 1, q_a.pop_front(), gapc_a);
                gapc_a = 1;
            end
        end else if (busy_a === 1'b1) begin
            inf_a     = 1;
            wave_a    = '0;
            wave_a[0] = tx_a;
            n_a       = 1;
        end else begin
            gapc_a++;
        end
    end

    logic [127:0] wave_b;
    int           n_b    = 0;
    bit           inf_b  = 0;
    int           gapc_b = 0;
    always @(negedge clk) begin
        if (inf_b) begin
            if (busy_b === 1'b1) begin
                if (n_b < 128) wave_b[n_b] = tx_b;
                n_b++;
            end else begin
                inf_b = 0;
                if (q_b.size() == 0) check("B unexpected_frame", 1, 0);
                else eval_frame("B", wave_b, n_b, 3, 2, q_b.pop_front(), gapc_b);
                gapc_b = 1;
            end
        end else if (busy_b === 1'b1) begin
            inf_b     = 1;
            wave_b    = '0;
            wave_b[0] = tx_b;
            n_b       = 1;
        end else begin
            gapc_b++;
        end
    end

    task automatic send_a(input logic [7:0] d, input int gap, input bit lat);
        exp_t e;
        int   t;
        e.data = d; e.abort = 0; e.gap = gap;
        q_a.push_back(e);
        @(negedge clk);
        data_a = d;
        req_a  = 1'b1;
        @(negedge clk);
        if (lat) begin
            check("A ack_rise_latency", int'(ack_a), 1);
            check("A busy_rise_latency", int'(busy_a), 1);
            check("A tx_start_latency", int'(tx_a), 0);
        end
        t = 0;
        while (ack_a !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("A ack_rise_wait", int'(ack_a === 1'b1), 1);
        req_a  = 1'b0;
        data_a = ~d;
        @(negedge clk);
        check("A ack_fall", int'(ack_a), 0);
    endtask

    task automatic send_b(input logic [7:0] d);
        exp_t e;
        e.data = d; e.abort = 0; e.gap = -1;
        q_b.push_back(e);
        @(negedge clk);
        data_b = d;
        req_b  = 1'b1;
        @(negedge clk);
        check("B ack_rise_latency", int'(ack_b), 1);
        check("B tx_start_latency", int'(tx_b), 0);
        req_b  = 1'b0;
        data_b = ~d;
        @(negedge clk);
        check("B ack_fall", int'(ack_b), 0);
    endtask

    task automatic wait_idle_a();
        int t;
        t = 0;
        while (busy_a !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("A idle_wait", int'(busy_a === 1'b0), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int   bad;
        int   t;
        exp_t e;
        clr_a = 1'b0; req_a = 1'b0; data_a = 8'h00;
        clr_b = 1'b0; req_b = 1'b0; data_b = 8'h00;
        repeat (3) @(negedge clk);
        check("A reset_tx", int'(tx_a), 1);
        check("A reset_ack_busy", int'({ack_a, busy_a}), 0);
        clr_a = 1'b1;
        clr_b = 1'b1;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || ack_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        check("A idle_quiet", bad, 0);

        send_a(8'hA5, -1, 1);
        wait_idle_a();

        send_a(8'h00, -1, 1);
        send_a(8'hFF, 1, 0);
        wait_idle_a();

        e.data = 8'h3C; e.abort = 0; e.gap = -1;
        q_a.push_back(e);
        @(negedge clk);
        data_a = 8'h3C;
        req_a  = 1'b1;
        t = 0;
        while (ack_a !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("A hold_ack_wait", int'(ack_a === 1'b1), 1);
        wait_idle_a();
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || tx_a !== 1'b1) bad++;
        end
        check("A hold_no_second", bad, 0);
        req_a = 1'b0;
        @(negedge clk);
        check("A hold_ack_fall", int'(ack_a), 0);
        send_a(8'h3C, -1, 1);
        wait_idle_a();

        e.data = 8'h81; e.abort = 1; e.gap = -1;
        q_a.push_back(e);
        @(negedge clk);
        data_a = 8'h81;
        req_a  = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        repeat (42) @(negedge clk);
        clr_a = 1'b0;
        @(negedge clk);
        clr_a = 1'b1;
        check("A abort_tx", int'(tx_a), 1);
        check("A abort_ack_busy", int'({ack_a, busy_a}), 0);
        repeat (2) @(negedge clk);
        send_a(8'h81, -1, 1);
        wait_idle_a();

        send_b(8'h5A);
        t = 0;
        while (busy_b !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("B idle_wait", int'(busy_b === 1'b0), 1);
        repeat (3) @(negedge clk);

        check("A queue_drained", q_a.size(), 0);
        check("B queue_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit half of the UART link: accepts one byte at a time from a local producer over a four-phase REQ/ACK handshake and shifts it onto the TX line as one frame. Frame format: start bit (0), 8 data bits LSB first, 1 or 2 stop bits (1). The default bit period of 8 clk cycles matches the receive side's divide-by-8 bit clock, so the two ends interoperate without retuning. Sits between the byte source (command logic or test driver) and the FPGA TX pin.

## Interface

- CLKS_PER_BIT, 8, clk cycles per serial bit; legal range ≥ 2
- STOP_BITS, 1, number of stop bits; legal values 1 or 2
- clk  input  1  system clock; all logic on posedge
- clr  input  1  reset; one clock; reset is synchronous and active-low (clr = 0 resets on the next posedge)
- XMIT_REQ  input  1  producer request; XMIT_DATA valid while high
- XMIT_DATA  input  8  byte to send; must be stable while XMIT_REQ = 1 and XMIT_ACK = 0
- XMIT_ACK  output  1  registered; byte captured
- XMIT_BUSY  output  1  registered; high while a frame is on the line
- TX  output  1  registered serial line; idles high

## Operation

- State machine:
  - IDLE: TX = 1.
  - START: TX = 0 for 1 bit.
  - DATA: TX = shift[0] for 8 bits; bit index 0..7.
  - STOP: TX = 1 for STOP_BITS bits.
  - STOP → IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1. It clears on every state entry and on each DATA bit advance. A bit ends on the cycle the timer reaches CLKS_PER_BIT-1.
- Capture condition: state = IDLE, XMIT_REQ = 1, XMIT_ACK = 0. On that edge:
  - shift ← XMIT_DATA
  - state ← START
  - TX ← 0
  - XMIT_ACK ← 1
  - XMIT_BUSY ← 1
- DATA: at the end of each bit, shift right by 1 and increment the bit index. After index 7 completes, go to STOP.
- Handshake, four-phase:
  - XMIT_ACK falls on the edge after XMIT_REQ is sampled low while XMIT_ACK = 1.
  - XMIT_ACK is independent of frame progress; it may fall mid-frame.
  - If XMIT_REQ is still high when STOP ends, no new capture occurs. The FSM waits in IDLE until the handshake completes (REQ low, ACK low) and REQ rises again.
- XMIT_BUSY = 1 in START, DATA and STOP; 0 in IDLE.
- XMIT_DATA changes after capture have no effect on the frame in progress.
- XMIT_REQ rising while BUSY: held off. Capture happens on the first IDLE cycle in which the capture condition is true.
- Reset (clr = 0), including mid-frame:
  - TX = 1, XMIT_ACK = 0, XMIT_BUSY = 0, state = IDLE.
  - Timer, bit index and shift register cleared.
  - The partial frame is abandoned, never resumed. Reset has priority over all other events.
- Timer and bit index use ceil(log2) widths; no wrap beyond terminal counts.

## Timing

- Reset values: TX = 1, XMIT_ACK = 0, XMIT_BUSY = 0.
- Capture latency: TX falls and XMIT_ACK/XMIT_BUSY rise 1 cycle after the edge that samples the capture condition.
- Frame duration (TX low-start to IDLE entry): (1 + 8 + STOP_BITS) × CLKS_PER_BIT cycles. Default: 80 cycles.
- Each bit holds TX constant for exactly CLKS_PER_BIT cycles. Edges align to the bit timer wrap.
- Minimum inter-frame gap: STOP_BITS × CLKS_PER_BIT + 1 cycles of TX = 1. The +1 is the IDLE capture cycle.
- XMIT_ACK fall: 1 cycle after XMIT_REQ is sampled low.
- Producer turnaround: REQ can rise again the cycle after ACK is seen low.

## Test plan

- Reset then idle, 20 cycles with XMIT_REQ = 0 → TX = 1, XMIT_ACK = 0, XMIT_BUSY = 0 throughout.
- Send 0xA5, defaults → TX = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles. XMIT_ACK rises 1 cycle after REQ. XMIT_BUSY is high for exactly 80 cycles.
- Back-to-back 0x00 then 0xFF with the producer turning REQ around immediately → second start bit begins 9 cycles after the first frame's stop bit begins. The 0xFF frame shows 8 cycles low, then 72 cycles high.
- Hold XMIT_REQ high through a full 0x3C frame → exactly one frame sent. No second frame until REQ falls, XMIT_ACK falls, and REQ rises again.
- Assert clr = 0 for 1 cycle at bit 4 of a 0x81 frame → next cycle TX = 1, XMIT_ACK = 0, XMIT_BUSY = 0. A fresh request for 0x81 then produces a complete, correct frame.
- CLKS_PER_BIT = 3, STOP_BITS = 2, send 0x5A → every bit is 3 cycles, the stop level lasts 6 cycles, and the total frame is 33 cycles.
